// File: rtl/ieeedrv_src_hs.sv
// IEEE-488 source handshake engine: drives data/ATN/EOI/DAV towards the bus
// acceptors and sequences one byte per request through the NRFD/NDAC handshake.
package ieeedrv_pkg;
    typedef struct packed {
        logic [7:0] data;
        logic       dav;
        logic       eoi;
        logic       atn;
        logic       ren;
        logic       ifc;
        logic       srq;
        logic       nrfd;
        logic       ndac;
    } st_ieee_bus;
endpackage

// Handshake on the byte port: a byte transfers on any cycle where
// tx_valid=1 and tx_ready=1; tx_ready is high only in IDLE and nothing is queued.
module ieeedrv_src_hs
    import ieeedrv_pkg::*;
#(
    parameter int unsigned SETTLE  = 2,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  st_ieee_bus bus_i,
    output st_ieee_bus bus_o,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       atn_hold,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETTLE,
        S_WAIT_RFD,
        S_DAV_ON,
        S_WAIT_DAC,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        atn_q, atn_d;
    logic        eoi_q, eoi_d;
    logic        dav_q, dav_d;
    logic        long_q, long_d;
    logic [1:0]  err_code_q;
    logic [1:0]  err_now;

    logic [16:0] settle_len;
    logic [16:0] cnt_inc;
    logic        settle_done;
    logic        timed_out;

    logic        unused_bus;
    assign unused_bus = ^{bus_i.data, bus_i.dav, bus_i.eoi, bus_i.atn,
                          bus_i.ren, bus_i.ifc, bus_i.srq};

    // An ATN change on the new byte doubles the settle time before DAV.
    assign settle_len  = long_q ? 17'(2 * SETTLE) : 17'(SETTLE);
    assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
    assign settle_done = ({1'b0, cnt_q} >= settle_len) || (ce && (cnt_inc >= settle_len));
    assign timed_out   = (cnt_q >= TIMEOUT);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        atn_d    = atn_q;
        eoi_d    = eoi_q;
        dav_d    = dav_q;
        long_d   = long_q;
        tx_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        err_now  = 2'd0;

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                atn_d    = atn_q & atn_hold;
                if (tx_valid) begin
                    data_d  = tx_data;
                    atn_d   = tx_atn;
                    eoi_d   = tx_eoi & ~tx_atn;
                    long_d  = (tx_atn != atn_q);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!bus_i.nrfd && !bus_i.ndac) begin
                    err     = 1'b1;
                    err_now = 2'd1;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_done) state_d = S_WAIT_RFD;
            end
            S_WAIT_RFD: begin
                if (!bus_i.nrfd) begin
                    dav_d   = 1'b1;
                    state_d = S_DAV_ON;
                end else if (timed_out) begin
                    err     = 1'b1;
                    err_now = 2'd2;
                    state_d = S_RELEASE;
                end
            end
            S_DAV_ON: begin
                state_d = S_WAIT_DAC;
            end
            S_WAIT_DAC: begin
                if (!bus_i.ndac) begin
                    done    = 1'b1;
                    state_d = S_RELEASE;
                end else if (timed_out) begin
                    err     = 1'b1;
                    err_now = 2'd3;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                atn_d   = atn_q & atn_hold;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Lines drop on the way into RELEASE so DAV is gone before new data appears.
        if (state_d == S_RELEASE && state_q != S_RELEASE) begin
            dav_d  = 1'b0;
            eoi_d  = 1'b0;
            data_d = 8'h00;
            atn_d  = atn_q & atn_hold;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (ce && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            data_q     <= 8'h00;
            atn_q      <= 1'b0;
            eoi_q      <= 1'b0;
            dav_q      <= 1'b0;
            long_q     <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            atn_q      <= atn_d;
            eoi_q      <= eoi_d;
            dav_q      <= dav_d;
            long_q     <= long_d;
            err_code_q <= err_code;
        end
    end

    assign err_code  = err ? err_now : err_code_q;
    assign dbg_state = state_q;

    always_comb begin
        bus_o      = '0;
        bus_o.data = data_q;
        bus_o.dav  = dav_q;
        bus_o.eoi  = eoi_q;
        bus_o.atn  = atn_q;
    end

endmodule

// File: tb/tb_ieeedrv_src_hs.sv
// Bench for ieeedrv_src_hs: a bus listener model plus a timeline model that
// predicts done/err cycles, codes, captured bytes and idle line levels.
module tb_ieeedrv_src_hs;
    import ieeedrv_pkg::*;

    localparam int S     = 3;
    localparam int T     = 20;
    localparam int NEVER = 100000;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_atn = 1'b0;
    logic       tx_eoi = 1'b0;
    logic       tx_valid = 1'b0;
    logic       atn_hold = 1'b0;
    logic       l_nrfd = 1'b1;
    logic       l_ndac = 1'b1;
    st_ieee_bus bus_in;
    st_ieee_bus bus_out;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cur_atn = 0;
    int last_code = 0;
    logic [9:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    always_comb begin
        bus_in      = '0;
        bus_in.nrfd = l_nrfd;
        bus_in.ndac = l_ndac;
    end

    ieeedrv_src_hs #(.SETTLE(S), .TIMEOUT(16'(T))) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .bus_i     (bus_in),
        .bus_o     (bus_out),
        .tx_data   (tx_data),
        .tx_atn    (tx_atn),
        .tx_eoi    (tx_eoi),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .atn_hold  (atn_hold),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ce_at(input int t, input int cm);
        return (cm == 0) || (t % 2 == 0);
    endfunction

    // First cycle in WAIT_RFD: the settle phase ends in the cycle carrying the len-th tick.
    function automatic int settle_end(input int start, input int len, input int cm);
        int n = 0;
        for (int x = start; x < start + 1000; x++) begin
            if (ce_at(x, cm)) n++;
            if (n >= len) return x + 1;
        end
        return -1;
    endfunction

    // Cycle at which T ticks have elapsed since entering a wait state at 'start'.
    function automatic int tmo_cycle(input int start, input int cm);
        int n = 0;
        for (int y = start; y < start + 1000; y++) begin
            if (n >= T) return y;
            if (ce_at(y, cm)) n++;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            tx_valid = 1'b0;
            ce = 1'b1;
        end
    endtask

    // mode 0: listener present (nrfd released r cycles after CHECK, ndac dd cycles
    // after DAV); mode 1: no listener. xv: extra busy cycles tx_valid stays high.
    task automatic send_byte(input logic [7:0] d, input logic a, input logic e, input logic hold,
                             input int mode, input int r, input int dd, input int cm,
                             input int xv, input int rst_rel);
        int exp_out, exp_code, exp_dav, exp_ready, len, w, c, tm, e2, acc, tm2;
        bit exp_done;
        int done_cyc = -1;
        int err_cyc = -1;
        int ready_cyc = -1;
        int dav_cyc = -1;
        int n_done = 0;
        int n_err = 0;
        int code_seen = -1;
        int bad_dav = 0;
        int both = 0;
        bit rst_hit = 0;

        len = (int'(a) != cur_atn) ? 2 * S : S;
        exp_done = 1'b0;
        exp_dav = -1;
        if (mode == 1) begin
            exp_out = 1;
            exp_code = 1;
        end else begin
            w  = settle_end(2, len, cm);
            c  = (1 + r > w) ? 1 + r : w;
            tm = tmo_cycle(w, cm);
            if (c > tm) begin
                exp_out = tm;
                exp_code = 2;
            end else begin
                exp_dav = c + 1;
                e2  = c + 2;
                acc = (c + 1 + dd > e2) ? c + 1 + dd : e2;
                tm2 = tmo_cycle(e2, cm);
                if (acc <= tm2) begin
                    exp_done = 1'b1;
                    exp_out = acc;
                    exp_code = last_code;
                end else begin
                    exp_out = tm2;
                    exp_code = 3;
                end
            end
        end
        exp_ready = exp_out + 2;
        if (exp_dav >= 0) exp_q.push_back({a, e & ~a, d});

        for (int t = 0; t < 400; t++) begin
            @(posedge clk_sys); #1;
            if (dav_cyc < 0 && bus_out.dav) begin
                dav_cyc = t;
                if (l_nrfd !== 1'b0) bad_dav++;
                if (exp_q.size() == 0) check_eq("dav_unexpected", 1, 0);
                else check_eq("dav_byte", int'({bus_out.atn, bus_out.eoi, bus_out.data}),
                              int'(exp_q.pop_front()));
            end
            ce       = ce_at(t, cm);
            tx_valid = (t <= xv);
            tx_data  = (t == 0) ? d : 8'($urandom);
            tx_atn   = (t == 0) ? a : 1'($urandom);
            tx_eoi   = (t == 0) ? e : 1'($urandom);
            atn_hold = hold;
            if (mode == 1) begin
                l_nrfd = 1'b0;
                l_ndac = 1'b0;
            end else begin
                l_nrfd = !(t >= 1 + r);
                l_ndac = !(dav_cyc >= 0 && t >= dav_cyc + dd);
            end
            if (rst_rel >= 0 && dav_cyc >= 0 && t == dav_cyc + rst_rel) begin
                #2 reset = 1'b1;
                #1;
                check_eq("rst_bus", int'(bus_out), 0);
                check_eq("rst_ready", int'(tx_ready), 1);
                check_eq("rst_done", int'(done), 0);
                rst_hit = 1;
                break;
            end
            @(negedge clk_sys);
            if (t == 0) check_eq("ready_at_accept", int'(tx_ready), 1);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (err) begin
                n_err++;
                if (err_cyc < 0) begin
                    err_cyc = t;
                    code_seen = int'(err_code);
                end
            end
            if (done && err) both++;
            if (t > 0 && tx_ready && ready_cyc < 0) begin
                ready_cyc = t;
                break;
            end
        end

        if (rst_hit) begin
            @(posedge clk_sys); #1;
            reset  = 1'b0;
            l_nrfd = 1'b0;
            l_ndac = 1'b0;
            tx_valid = 1'b0;
            ce = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_sys);
                if (done) n_done++;
                if (err) n_err++;
            end
            check_eq("rst_no_pulse", n_done + n_err, 0);
            check_eq("rst_idle_ready", int'(tx_ready), 1);
            check_eq("rst_code", int'(err_code), 0);
            exp_q.delete();
            cur_atn = 0;
            last_code = 0;
            return;
        end

        if (exp_done) begin
            check_eq("done_cycle", done_cyc, exp_out);
            check_eq("no_err", err_cyc, -1);
        end else begin
            check_eq("err_cycle", err_cyc, exp_out);
            check_eq("err_code", code_seen, exp_code);
            check_eq("no_done", done_cyc, -1);
        end
        check_eq("one_pulse", n_done + n_err, 1);
        check_eq("exclusive", both, 0);
        check_eq("dav_cycle", dav_cyc, exp_dav);
        check_eq("dav_after_rfd", bad_dav, 0);
        check_eq("ready_cycle", ready_cyc, exp_ready);
        check_eq("rel_lines", int'({bus_out.data, bus_out.eoi, bus_out.dav}), 0);
        check_eq("rel_atn", int'(bus_out.atn), int'(a & hold));
        check_eq("code_held", int'(err_code), exp_code);
        check_eq("exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
        last_code = exp_code;
        cur_atn = int'(a & hold);
        l_nrfd = 1'b1;
        l_ndac = 1'b1;
    endtask

    initial begin
        int m, r, dd;
        #1 reset = 1'b1;
        #2;
        check_eq("reset_bus", int'(bus_out), 0);
        check_eq("reset_ready", int'(tx_ready), 1);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_err", int'(err), 0);
        check_eq("reset_code", int'(err_code), 0);
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        idle(2);

        send_byte(8'h41, 1'b0, 1'b1, 1'b0, 0, 3, 2, 0, 0, -1);
        send_byte(8'h28, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, -1);
        send_byte(8'hF0, 1'b1, 1'b1, 1'b1, 0, 1, 1, 0, 0, -1);
        send_byte(8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, -1);
        send_byte(8'h3F, 1'b1, 1'b0, 1'b1, 0, 2, 3, 0, 0, -1);

        // atn_hold falling while idle clears ATN one cycle later
        @(posedge clk_sys); #1 atn_hold = 1'b0;
        @(negedge clk_sys);
        check_eq("hold_drop_same", int'(bus_out.atn), 1);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        check_eq("hold_drop_next", int'(bus_out.atn), 0);
        cur_atn = 0;

        send_byte(8'h55, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, -1);
        send_byte(8'h66, 1'b0, 1'b0, 1'b0, 0, NEVER, 0, 0, 0, -1);
        send_byte(8'h77, 1'b0, 1'b1, 1'b0, 0, 1, NEVER, 0, 0, -1);
        send_byte(8'h88, 1'b1, 1'b0, 1'b1, 0, 2, 2, 1, 0, -1);
        send_byte(8'h99, 1'b0, 1'b0, 1'b0, 0, 4, 1, 0, 2, -1);
        send_byte(8'hAA, 1'b0, 1'b1, 1'b0, 0, 0, NEVER, 0, 0, 2);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            m  = $urandom_range(0, 9);
            r  = $urandom_range(0, 6);
            dd = $urandom_range(0, 5);
            if (m == 1) r = NEVER;
            if (m == 2) dd = NEVER;
            send_byte(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                      (m == 0) ? 1 : 0, r, dd, $urandom_range(0, 1), $urandom_range(0, 2), -1);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ieeedrv_src_hs.md
# ieeedrv_src_hs

Controller-side IEEE-488 source handshake engine. It transmits command bytes (under ATN) and data bytes (optionally tagged EOI) to the drive's acceptor over the `st_ieee_bus` structure. It is the talker/controller counterpart of the drive logic and is used by the host-side bus model and by the drive test bench. Bytes are accepted one at a time through a valid/ready port. Each transfer ends with a single-cycle done pulse or an error pulse.

## Interface
Parameters:
- SETTLE, 2: `ce` ticks that data/ATN/EOI are held stable before DAV is asserted.
- TIMEOUT, 16'd4000: `ce` ticks allowed per wait state before an error is raised.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  timing tick; all waits and counters advance only when ce=1.
- bus_i  in  st_ieee_bus  bus as seen from outside. Uses fields nrfd and ndac; 1 = line asserted (low on the wire).
- bus_o  out  st_ieee_bus  this node's drive. Uses fields data[7:0], dav, eoi and atn; 1 = asserted. All other fields are 0.
- tx_data  in  8  byte to send.
- tx_atn  in  1  byte is a command byte (ATN asserted).
- tx_eoi  in  1  byte is the last one (EOI asserted with DAV). Ignored when tx_atn=1.
- tx_valid  in  1  request to send.
- tx_ready  out  1  engine is idle and will take the byte presented on this cycle.
- atn_hold  in  1  keep ATN asserted while idle after a command byte.
- done  out  1  one-cycle pulse: the byte was accepted by all listeners.
- err  out  1  one-cycle pulse: no listener, or timeout.
- err_code  out  2  valid with err. 1 = no listener; 2 = NRFD timeout; 3 = NDAC timeout. Holds its last value otherwise.

## Operation
- States: IDLE, CHECK, SETTLE, WAIT_RFD, DAV_ON, WAIT_DAC, RELEASE.
- IDLE: tx_ready=1. When tx_valid=1, latch the byte into internal registers and go to CHECK.
  - Latched fields: data, atn = tx_atn, and eoi = tx_eoi & ~tx_atn.
  - bus_o.data, eoi and atn drive the latched values starting the next cycle.
- CHECK (one cycle): if bus_i.nrfd=0 and bus_i.ndac=0, no listener is present.
  - Pulse err with code 1 and go to RELEASE.
  - Otherwise clear the counter and go to SETTLE.
- SETTLE: count SETTLE `ce` ticks, then go to WAIT_RFD.
- WAIT_RFD: wait for bus_i.nrfd=0, then go to DAV_ON.
  - After TIMEOUT ticks: err with code 2, then RELEASE.
- DAV_ON (one cycle): set bus_o.dav=1 and go to WAIT_DAC.
- WAIT_DAC: wait for bus_i.ndac=0, then pulse done and go to RELEASE.
  - After TIMEOUT ticks: err with code 3, then RELEASE.
- RELEASE (one cycle):
  - Clear dav, eoi and data to 0.
  - Set atn to (latched atn & atn_hold).
  - Go to IDLE.
- ATN while idle: if atn_hold falls, bus_o.atn clears on the next cycle.
- ATN transition on a new byte: if the new byte's tx_atn differs from the current bus_o.atn, SETTLE is lengthened to 2*SETTLE ticks. This gives listeners time to respond to the ATN change before DAV.
- The counter is 16 bits wide. It clears on every state entry and saturates (does not wrap).
- tx_valid while not IDLE is ignored; the byte is not queued.

## Timing
- Reset values: bus_o all fields 0, tx_ready=1, done=0, err=0, err_code=0, state IDLE.
- Reset asserted mid-transfer releases all bus lines asynchronously and returns the engine to IDLE.
- Minimum latency with ce=1 every cycle and a listener that responds immediately: tx_valid accepted at cycle 0.
  - Cycle 1: CHECK.
  - Cycles 2..SETTLE+1: SETTLE.
  - Cycle SETTLE+2: WAIT_RFD.
  - Cycle SETTLE+3: DAV_ON.
  - Cycle SETTLE+4: WAIT_DAC, with done asserted in that same cycle if ndac=0.
  - Next cycle: RELEASE. tx_ready returns one cycle after that.
- DAV is never asserted unless nrfd=0 was sampled in the previous cycle.
- DAV is always released in RELEASE before any new data is driven.
- done and err are mutually exclusive and each lasts exactly one clk_sys cycle.
- If nrfd and ndac are both released in WAIT_DAC, that is a normal accept, not an error.

## Test plan
- Single data byte 0x41, tx_eoi=1, model listener (NRFD released 3 ticks after CHECK, NDAC released 2 ticks after DAV) -> the listener captures 0x41 with eoi=1, done pulses once, dav=0 afterward, err never asserts.
- Command sequence 0x28, 0xF0 with tx_atn=1 and atn_hold=1, then data byte 0x00 with tx_atn=0 -> atn stays 1 between the command bytes, the data byte uses a 2*SETTLE settle period, and atn=0 during the data byte.
- No listener (nrfd=0, ndac=0 held) -> err pulses with err_code=1 in CHECK, dav never asserts, tx_ready returns within 2 cycles.
- Listener holds nrfd=1 forever -> err_code=2 exactly TIMEOUT ticks after entering WAIT_RFD, dav stays 0.
- Listener holds ndac=1 after DAV -> err_code=3 after TIMEOUT ticks, dav released in RELEASE.
- Reset asserted during WAIT_DAC -> all bus_o fields are 0 immediately (before the next clock), tx_ready=1, and no done pulse follows.
